// File: rtl/trace_pkg.sv
// rtl/trace_pkg.sv - shared types for the memory write trace buffer
package trace_pkg;

    localparam int TRACE_ADDR_W = 15;
    localparam int TRACE_DATA_W = 16;
    localparam int TRACE_SEQ_W  = 8;
    localparam int TRACE_TIME_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } trace_state_e;

    // Field order matches the packed FIFO word built in mem_write_trace.
    typedef struct packed {
        logic [TRACE_ADDR_W-1:0] addr;
        logic [TRACE_DATA_W-1:0] data;
        logic [TRACE_SEQ_W-1:0]  seq;
    } trace_entry_t;

endpackage

// File: rtl/mem_write_trace_if.sv
// rtl/mem_write_trace_if.sv - core write bus and host drain port (TRACE_TIMESTAMP_EN adds out_time)
interface mem_write_trace_if #(
    parameter int ADDR_W = 15,
    parameter int DATA_W = 16,
    parameter int SEQ_W  = 8
);
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              out_valid;
    logic              out_ready;
    logic [ADDR_W-1:0] out_addr;
    logic [DATA_W-1:0] out_data;
    logic [SEQ_W-1:0]  out_seq;
`ifdef TRACE_TIMESTAMP_EN
    logic [31:0]       out_time;

    modport master (
        output wr_en, wr_addr, wr_data, out_ready,
        input  out_valid, out_addr, out_data, out_seq, out_time
    );
    modport slave (
        input  wr_en, wr_addr, wr_data, out_ready,
        output out_valid, out_addr, out_data, out_seq, out_time
    );
`else
    modport master (
        output wr_en, wr_addr, wr_data, out_ready,
        input  out_valid, out_addr, out_data, out_seq
    );
    modport slave (
        input  wr_en, wr_addr, wr_data, out_ready,
        output out_valid, out_addr, out_data, out_seq
    );
`endif
endinterface

// File: rtl/trace_fifo.sv
// rtl/trace_fifo.sv - first-word-fall-through FIFO holding trace entries
module trace_fifo #(
    parameter int W     = 39,
    parameter int DEPTH = 16,
    localparam int PW   = $clog2(DEPTH),
    localparam int LW   = PW + 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] wdata,
    output logic [W-1:0] rdata,
    output logic         valid,
    output logic [LW-1:0] level
);
    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Caller guarantees push only when not full or popping, pop only when valid.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

    assign valid = (level != '0);
    // Storage is not reset, so the head is forced to zero while empty.
    assign rdata = valid ? mem[rd_ptr] : '0;

endmodule

// File: rtl/mem_write_trace.sv
// rtl/mem_write_trace.sv - windowed capture of core memory writes into a drainable FIFO
// Optional TRACE_TIMESTAMP_EN stamps each entry with a free-running cycle count.
module mem_write_trace
    import trace_pkg::*;
#(
    parameter int ADDR_W = TRACE_ADDR_W,
    parameter int DATA_W = TRACE_DATA_W,
    parameter int DEPTH  = 16,
    parameter int SEQ_W  = TRACE_SEQ_W,
    parameter int CNT_W  = 16,
    localparam int LW    = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              arm,
    input  logic              abort,
    input  logic [CNT_W-1:0]  stop_count,
    input  logic [ADDR_W-1:0] win_lo,
    input  logic [ADDR_W-1:0] win_hi,
    mem_write_trace_if.slave  bus,
    output logic [LW-1:0]     level,
    output logic [CNT_W-1:0]  captured,
    output logic [CNT_W-1:0]  dropped,
    output logic [1:0]        state_o
);
`ifdef TRACE_TIMESTAMP_EN
    localparam int EW = ADDR_W + DATA_W + SEQ_W + TRACE_TIME_W;
    logic [TRACE_TIME_W-1:0] time_cnt;
`else
    localparam int EW = ADDR_W + DATA_W + SEQ_W;
`endif

    trace_state_e     state;
    logic [SEQ_W-1:0] seq;
    logic             hit, pop, push, full, arm_go;
    logic [EW-1:0]    wdata, rdata;

    assign hit    = (state == RUN) && bus.wr_en &&
                    (bus.wr_addr >= win_lo) && (bus.wr_addr <= win_hi);
    assign pop    = bus.out_valid && bus.out_ready;
    assign full   = (level == LW'(DEPTH));
    assign push   = hit && (!full || pop);
    assign arm_go = arm && !abort && (state != RUN);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            captured <= '0;
            dropped  <= '0;
            seq      <= '0;
        end else begin
            if (arm_go) begin
                captured <= '0;
                dropped  <= '0;
                seq      <= '0;
            end else if (push) begin
                captured <= captured + CNT_W'(1);
                seq      <= seq + SEQ_W'(1);
            end else if (hit && (dropped != '1)) begin
                dropped  <= dropped + CNT_W'(1);
            end

            if (abort) begin
                state <= IDLE;
            end else if (arm_go) begin
                state <= RUN;
            end else if (push && (stop_count != '0) &&
                         (captured + CNT_W'(1) == stop_count)) begin
                state <= DONE;
            end
        end
    end

    assign state_o = state;

`ifdef TRACE_TIMESTAMP_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            time_cnt <= '0;
        end else if (arm_go) begin
            time_cnt <= '0;
        end else begin
            time_cnt <= time_cnt + 32'd1;
        end
    end

    assign wdata = {bus.wr_addr, bus.wr_data, seq, time_cnt};
    assign {bus.out_addr, bus.out_data, bus.out_seq, bus.out_time} = rdata;
`else
    assign wdata = {bus.wr_addr, bus.wr_data, seq};
    assign {bus.out_addr, bus.out_data, bus.out_seq} = rdata;
`endif

    trace_fifo #(
        .W     (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .wdata (wdata),
        .rdata (rdata),
        .valid (bus.out_valid),
        .level (level)
    );

endmodule

// File: tb/tb_mem_write_trace.sv
// tb/tb_mem_write_trace.sv - directed bench with queue-based reference model (TRACE_TIMESTAMP_EN aware)
module tb_mem_write_trace;
    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        arm, abort;
    logic [15:0] stop_count;
    logic [14:0] win_lo, win_hi;
    logic [4:0]  level;
    logic [15:0] captured, dropped;
    logic [1:0]  state_o;

    int checks = 0;
    int errors = 0;

    mem_write_trace_if bus ();

    mem_write_trace #(.DEPTH(DEPTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .arm        (arm),
        .abort      (abort),
        .stop_count (stop_count),
        .win_lo     (win_lo),
        .win_hi     (win_hi),
        .bus        (bus),
        .level      (level),
        .captured   (captured),
        .dropped    (dropped),
        .state_o    (state_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [14:0] a;
        logic [15:0] d;
        logic [7:0]  s;
        logic [31:0] t;
    } exp_t;

    exp_t        m_q[$];
    int          m_st;
    logic [15:0] m_cap, m_drp;
    logic [7:0]  m_seq;
    logic [31:0] m_tm;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference model: trace as a list of accepted writes plus counters.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_q.delete();
            m_st = 0; m_cap = 0; m_drp = 0; m_seq = 0; m_tm = 0;
        end else begin
            bit h, p, u, go;
            h  = (m_st == 1) && bus.wr_en && (bus.wr_addr >= win_lo) && (bus.wr_addr <= win_hi);
            p  = (m_q.size() > 0) && bus.out_ready;
            u  = h && ((m_q.size() < DEPTH) || p);
            go = arm && !abort && (m_st != 1);
            if (p) void'(m_q.pop_front());
            if (u) begin
                m_q.push_back('{a: bus.wr_addr, d: bus.wr_data, s: m_seq, t: m_tm});
                m_cap++;
                m_seq++;
            end else if (h && m_drp != 16'hFFFF) begin
                m_drp++;
            end
            if (abort) m_st = 0;
            else if (go) begin
                m_st = 1; m_cap = 0; m_drp = 0; m_seq = 0;
            end else if (u && stop_count != 0 && m_cap == stop_count) m_st = 2;
            m_tm = go ? 32'd0 : m_tm + 32'd1;
        end
    end

    always @(negedge clk) begin
        if (reset) begin
            chk("valid", bus.out_valid, m_q.size() != 0);
            chk("level", level, m_q.size());
            chk("captured", captured, m_cap);
            chk("dropped", dropped, m_drp);
            chk("state", state_o, m_st);
            if (m_q.size() != 0) begin
                chk("head_addr", bus.out_addr, m_q[0].a);
                chk("head_data", bus.out_data, m_q[0].d);
                chk("head_seq", bus.out_seq, m_q[0].s);
`ifdef TRACE_TIMESTAMP_EN
                chk("head_time", bus.out_time, m_q[0].t);
`endif
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic pulse_arm();
        arm = 1'b1; tick(); arm = 1'b0;
    endtask

    task automatic pulse_abort();
        abort = 1'b1; tick(); abort = 1'b0;
    endtask

    task automatic write(input logic [14:0] a, input logic [15:0] d);
        bus.wr_en = 1'b1; bus.wr_addr = a; bus.wr_data = d;
        tick();
        bus.wr_en = 1'b0;
    endtask

    task automatic drain(input int n);
        bus.out_ready = 1'b1;
        for (int i = 0; i < n; i++) tick();
        bus.out_ready = 1'b0;
    endtask

    initial begin
        reset = 1'b0; arm = 1'b0; abort = 1'b0; stop_count = 16'd0;
        win_lo = 15'd0; win_hi = 15'h3FFF;
        bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0; bus.out_ready = 1'b0;
        repeat (3) tick();
        reset = 1'b1;
        tick();
        chk("rst_valid", bus.out_valid, 1'b0);
        chk("rst_level", level, 5'd0);
        chk("rst_state", state_o, 2'd0);
        chk("rst_data", {bus.out_addr, bus.out_data, bus.out_seq}, 39'd0);

        // Five in-window writes, drained in order.
        pulse_arm();
        chk("arm_state", state_o, 2'd1);
        for (int i = 1; i <= 5; i++) write(15'd16, 16'(i));
        chk("t2_level", level, 5'd5);
        bus.out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("t2_data", bus.out_data, 16'(i + 1));
            chk("t2_seq", bus.out_seq, 8'(i));
            tick();
        end
        bus.out_ready = 1'b0;
        chk("t2_empty", level, 5'd0);

        // Single-address window boundaries.
        win_lo = 15'h4000; win_hi = 15'h4000;
        write(15'h3FFF, 16'h000A);
        write(15'h4000, 16'h000B);
        write(15'h4001, 16'h000C);
        chk("t3_level", level, 5'd1);
        chk("t3_addr", bus.out_addr, 15'h4000);
        chk("t3_data", bus.out_data, 16'h000B);
        chk("t3_seq", bus.out_seq, 8'd5);
        drain(1);

        // Overflow, then full with simultaneous pop and hit.
        pulse_abort();
        pulse_arm();
        win_lo = 15'd0; win_hi = 15'h7FFF;
        for (int i = 0; i < 20; i++) write(15'h100 + 15'(i), 16'(i));
        chk("t4_level", level, 5'd16);
        chk("t4_dropped", dropped, 16'd4);
        chk("t4_captured", captured, 16'd16);
        chk("t4_headseq", bus.out_seq, 8'd0);
        bus.out_ready = 1'b1;
        write(15'h7FFF, 16'hBEEF);
        bus.out_ready = 1'b0;
        chk("t4_fullpop_level", level, 5'd16);
        chk("t4_fullpop_seq", bus.out_seq, 8'd1);
        drain(17);
        win_lo = 15'd10; win_hi = 15'd5;
        write(15'd7, 16'h1234);
        chk("t4_inverted_win", level, 5'd0);
        chk("t4_inverted_drop", dropped, 16'd4);

        // Auto-stop after three captures, then re-arm restarts sequence.
        win_lo = 15'd0; win_hi = 15'h7FFF;
        pulse_abort();
        stop_count = 16'd3;
        pulse_arm();
        for (int i = 0; i < 5; i++) begin
            write(15'h20, 16'(i));
            if (i == 2) chk("t5_done_after3", state_o, 2'd2);
        end
        chk("t5_level", level, 5'd3);
        chk("t5_captured", captured, 16'd3);
        chk("t5_dropped", dropped, 16'd0);
        drain(3);
        pulse_arm();
        chk("t5_rearm", state_o, 2'd1);
        write(15'h21, 16'h5555);
        chk("t5_seq0", bus.out_seq, 8'd0);
        drain(1);
        stop_count = 16'd0;

        // Abort wins over arm.
        pulse_abort();
        arm = 1'b1; abort = 1'b1;
        tick();
        arm = 1'b0; abort = 1'b0;
        chk("t6_abort_wins", state_o, 2'd0);

`ifdef TRACE_TIMESTAMP_EN
        begin
            logic [31:0] t0, t1;
            pulse_arm();
            for (int i = 0; i < 3; i++) begin
                write(15'h30, 16'(i));
                repeat (3) tick();
            end
            t0 = bus.out_time;
            for (int i = 0; i < 2; i++) begin
                drain(1);
                t1 = bus.out_time;
                chk("ts_delta", t1 - t0, 32'd4);
                t0 = t1;
            end
            drain(1);
            pulse_abort();
        end
`endif

        // Asynchronous reset in the middle of a run.
        pulse_arm();
        write(15'h40, 16'h1);
        write(15'h41, 16'h2);
        bus.wr_en = 1'b1;
        reset = 1'b0;
        #1;
        chk("t1_valid", bus.out_valid, 1'b0);
        chk("t1_level", level, 5'd0);
        chk("t1_state", state_o, 2'd0);
        chk("t1_captured", captured, 16'd0);
        repeat (3) tick();
        bus.wr_en = 1'b0;
        reset = 1'b1;
        tick();
        chk("t1_post_level", level, 5'd0);
        chk("t1_post_state", state_o, 2'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
